// File: rtl/fptr_alloc.sv
// fptr_alloc: consumer end of the free-pointer FIFO.
//
// After the init writer has filled the FIFO with every pointer, this block
// prefetches free pointers into a 2-entry skid buffer and offers them one
// per valid/ready handshake as buffer allocations. It also owns the FIFO
// write port once init is done, so released pointers go back into the pool.
// It tracks how many pointers are outstanding.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   init_done           init fill complete (sticky)
//   init_wen/wdata      init writer's FIFO write port
//   fptr_fifo_wen/wdata muxed FIFO write port (init writer, then releases)
//   fptr_fifo_empty     FIFO empty flag
//   fptr_fifo_ren       FIFO read enable
//   fptr_fifo_rdata     FIFO read data, valid the cycle after ren
//   alloc_vld/ptr/rdy   allocation handshake toward the packet writer
//   rel_wen/rel_ptr     pointer release from the packet reader
//   used_cnt            pointers allocated and not yet released
//   err                 sticky protocol error (bad release)
module fptr_alloc #(
  parameter int PTR_WID = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic               init_wen,
  input  logic [PTR_WID-1:0] init_wdata,
  output logic               fptr_fifo_wen,
  output logic [PTR_WID-1:0] fptr_fifo_wdata,
  input  logic               fptr_fifo_empty,
  output logic               fptr_fifo_ren,
  input  logic [PTR_WID-1:0] fptr_fifo_rdata,
  output logic               alloc_vld,
  output logic [PTR_WID-1:0] alloc_ptr,
  input  logic               alloc_rdy,
  input  logic               rel_wen,
  input  logic [PTR_WID-1:0] rel_ptr,
  output logic [PTR_WID:0]   used_cnt,
  output logic               err
);

  typedef enum logic {WAIT, RUN} state_t;

  state_t             state_q;
  logic [1:0]         occ_q, occ_d;         // skid entries held (0..2)
  logic               inflight_q;           // read issued last cycle, data arrives now
  logic [PTR_WID-1:0] ent0_q, ent0_d;       // head entry, drives alloc_ptr
  logic [PTR_WID-1:0] ent1_q, ent1_d;
  logic [PTR_WID:0]   used_q, used_d;
  logic               err_q, err_d;

  logic               pop;
  logic               push;
  logic [2:0]         lvl;
  logic               rel_uf;
  logic               rel_ok;

  assign alloc_vld = (occ_q != 2'd0);
  assign alloc_ptr = ent0_q;
  assign used_cnt  = used_q;
  assign err       = err_q;

  assign pop  = alloc_vld & alloc_rdy;
  assign push = inflight_q;

  // Projected skid level once this cycle's pop and the returning read land.
  // pop implies occ_q >= 1, so this never wraps.
  assign lvl = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign fptr_fifo_ren = (state_q == RUN) & ~fptr_fifo_empty & (lvl < 3'd2);

  // A release with nothing outstanding (and no transfer this cycle to cover
  // it) is bogus: it is flagged and kept out of the FIFO so the pool cannot
  // gain a duplicate pointer. used_q is only nonzero in RUN, so this also
  // rejects releases in the single WAIT cycle where init_done is already high.
  assign rel_uf = rel_wen & init_done & (used_q == '0) & ~pop;
  assign rel_ok = rel_wen & init_done & ~rel_uf;

  // Write port mux: init writer owns it until init_done, releases after.
  always_comb begin
    if (init_done) begin
      fptr_fifo_wen   = rel_ok;
      fptr_fifo_wdata = rel_ptr;
    end else begin
      fptr_fifo_wen   = init_wen;
      fptr_fifo_wdata = init_wdata;
    end
  end

  // Skid buffer: ent0 is always the oldest pointer so alloc_ptr comes
  // straight from a flop, never from fptr_fifo_rdata.
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = fptr_fifo_rdata;
        else               ent1_d = fptr_fifo_rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = fptr_fifo_rdata;
        end else begin
          ent0_d = fptr_fifo_rdata;
        end
      end
      default: ;
    endcase
  end

  // Outstanding count: a transfer and a release in the same cycle cancel.
  always_comb begin
    used_d = used_q;
    unique case ({pop, rel_ok})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: ;
    endcase
  end

  assign err_d = err_q | (rel_wen & ~init_done) | rel_uf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      used_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        WAIT:    if (init_done) state_q <= RUN;
        RUN:     state_q <= RUN;
        default: state_q <= WAIT;
      endcase
      occ_q      <= occ_d;
      inflight_q <= fptr_fifo_ren;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      used_q     <= used_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fptr_alloc.sv
// Bench for fptr_alloc with a 16-pointer pool. Models the free-pointer FIFO
// (1-cycle read latency) and keeps a pool-level reference: expected
// allocation order, the set of outstanding pointers, and the error flag.
module tb_fptr_alloc;
  localparam int PTR_WID = 4;
  localparam int N = 1 << PTR_WID;

  logic               clk = 1'b0;
  logic               rst;
  logic               init_done, init_wen;
  logic [PTR_WID-1:0] init_wdata;
  logic               fptr_fifo_wen;
  logic [PTR_WID-1:0] fptr_fifo_wdata;
  logic               fptr_fifo_empty;
  logic               fptr_fifo_ren;
  logic [PTR_WID-1:0] fptr_fifo_rdata;
  logic               alloc_vld;
  logic [PTR_WID-1:0] alloc_ptr;
  logic               alloc_rdy;
  logic               rel_wen;
  logic [PTR_WID-1:0] rel_ptr;
  logic [PTR_WID:0]   used_cnt;
  logic               err;

  always #5 clk = ~clk;

  fptr_alloc #(.PTR_WID(PTR_WID)) dut (
    .clk(clk), .rst(rst),
    .init_done(init_done), .init_wen(init_wen), .init_wdata(init_wdata),
    .fptr_fifo_wen(fptr_fifo_wen), .fptr_fifo_wdata(fptr_fifo_wdata),
    .fptr_fifo_empty(fptr_fifo_empty), .fptr_fifo_ren(fptr_fifo_ren),
    .fptr_fifo_rdata(fptr_fifo_rdata),
    .alloc_vld(alloc_vld), .alloc_ptr(alloc_ptr), .alloc_rdy(alloc_rdy),
    .rel_wen(rel_wen), .rel_ptr(rel_ptr),
    .used_cnt(used_cnt), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO model
  int                 fq[$];
  logic [PTR_WID-1:0] rd_q;
  int                 ren_cnt;

  // pool reference
  int exp_q[$];      // pointers in the order they must be allocated
  int out_list[$];   // outstanding pointers
  bit out_bits[N];
  bit m_err;

  // per-cycle samples
  int s_vld, s_ptr, s_hs, s_wen, s_wdata, s_used, s_err;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle. Caller sets inputs at the negedge; returns at next negedge.
  task automatic cyc();
    int  n_out_pre;
    bit  hs;
    bit  exp_wen;
    int  exp_wd;
    fptr_fifo_empty = (fq.size() == 0);
    fptr_fifo_rdata = rd_q;
    #1;
    s_vld   = int'(alloc_vld);
    s_ptr   = int'(alloc_ptr);
    s_wen   = int'(fptr_fifo_wen);
    s_wdata = int'(fptr_fifo_wdata);
    s_used  = int'(used_cnt);
    s_err   = int'(err);
    chk("used_cnt", s_used, out_list.size());
    chk("err", s_err, int'(m_err));

    n_out_pre = out_list.size();
    hs = alloc_vld && alloc_rdy;
    s_hs = int'(hs);
    if (hs) begin
      chk("alloc_avail", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("alloc_order", s_ptr, exp_q.pop_front());
      chk("dup", int'(out_bits[alloc_ptr]), 0);
      out_bits[alloc_ptr] = 1'b1;
      out_list.push_back(s_ptr);
    end

    exp_wen = 1'b0;
    exp_wd  = 0;
    if (!init_done) begin
      exp_wen = init_wen;
      exp_wd  = int'(init_wdata);
      if (init_wen) exp_q.push_back(int'(init_wdata));
      if (rel_wen) m_err = 1'b1;
    end else if (rel_wen) begin
      if (n_out_pre == 0 && !hs) begin
        m_err = 1'b1;
      end else begin
        exp_wen = 1'b1;
        exp_wd  = int'(rel_ptr);
        exp_q.push_back(int'(rel_ptr));
        out_bits[rel_ptr] = 1'b0;
        for (int i = 0; i < out_list.size(); i++)
          if (out_list[i] == int'(rel_ptr)) begin
            out_list.delete(i);
            break;
          end
      end
    end
    chk("fifo_wen", s_wen, int'(exp_wen));
    if (exp_wen) chk("fifo_wdata", s_wdata, exp_wd);

    if (fptr_fifo_ren) begin
      ren_cnt++;
      chk("ren_nonempty", int'(fq.size() > 0), 1);
      if (fq.size() > 0) rd_q = PTR_WID'(fq.pop_front());
    end
    if (fptr_fifo_wen) fq.push_back(int'(fptr_fifo_wdata));
    @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b1; init_done = 1'b0; init_wen = 1'b0; rel_wen = 1'b0;
    alloc_rdy = 1'b0;
    #1;
    chk("rst_ren", int'(fptr_fifo_ren), 0);
    chk("rst_vld", int'(alloc_vld), 0);
    chk("rst_ptr", int'(alloc_ptr), 0);
    chk("rst_used", int'(used_cnt), 0);
    chk("rst_err", int'(err), 0);
    fq.delete(); exp_q.delete(); out_list.delete();
    foreach (out_bits[i]) out_bits[i] = 1'b0;
    m_err = 1'b0; rd_q = '0; ren_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_init(input bit rel_during);
    for (int i = 0; i < N; i++) begin
      init_wen   = 1'b1;
      init_wdata = PTR_WID'(i);
      rel_wen    = rel_during && (i == 3);
      rel_ptr    = PTR_WID'(5);
      cyc();
    end
    init_wen  = 1'b0;
    rel_wen   = 1'b0;
    init_done = 1'b1;
  endtask

  initial begin
    int first, t0, t1, r, got;
    int seq[$];
    rst = 1'b1; init_done = 1'b0; init_wen = 1'b0; init_wdata = '0;
    alloc_rdy = 1'b0; rel_wen = 1'b0; rel_ptr = '0;
    fptr_fifo_empty = 1'b1; fptr_fifo_rdata = '0;
    @(negedge clk);

    // fill, then hold rdy low: two prefetches, vld 3 cycles after init_done
    do_rst();
    do_init(1'b0);
    first = -1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (s_vld != 0 && first < 0) first = k;
      if (s_vld != 0) chk("hold_ptr", s_ptr, 0);
    end
    chk("vld_latency", first, 3);
    chk("ren_pulses", ren_cnt, 2);

    // drain the whole pool at full rate
    alloc_rdy = 1'b1;
    t0 = -1; t1 = -1;
    for (int k = 0; k < 24; k++) begin
      cyc();
      if (s_hs != 0) begin
        seq.push_back(s_ptr);
        if (t0 < 0) t0 = k;
        t1 = k;
      end
    end
    chk("drain_count", seq.size(), N);
    for (int i = 0; i < seq.size(); i++) chk("drain_seq", seq[i], i);
    chk("drain_span", t1 - t0, N - 1);
    chk("drain_vld_end", s_vld, 0);
    r = ren_cnt;
    repeat (4) cyc();
    chk("empty_no_ren", ren_cnt - r, 0);
    chk("drain_used", s_used, N);
    chk("drain_err", s_err, 0);

    // release one pointer after exhaustion; it comes back around
    rel_wen = 1'b1; rel_ptr = PTR_WID'(7);
    cyc();
    rel_wen = 1'b0;
    chk("rel_wen", s_wen, 1);
    chk("rel_wdata", s_wdata, 7);
    cyc();
    chk("rel_used", s_used, N - 1);
    got = -1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (s_hs != 0 && got < 0) got = s_ptr;
    end
    chk("realloc_ptr", got, 7);
    cyc();
    chk("realloc_used", s_used, N);

    // random traffic
    for (int k = 0; k < 1000; k++) begin
      alloc_rdy = 1'($urandom_range(0, 1));
      rel_wen   = 1'b0;
      if (out_list.size() > 0 && $urandom_range(0, 2) == 0) begin
        rel_wen = 1'b1;
        rel_ptr = PTR_WID'(out_list[$urandom_range(0, out_list.size() - 1)]);
      end
      cyc();
    end
    rel_wen = 1'b0;

    // bad releases: during init and with nothing outstanding
    do_rst();
    do_init(1'b1);
    chk("err_init", s_err, 1);
    alloc_rdy = 1'b0;
    repeat (5) cyc();
    rel_wen = 1'b1; rel_ptr = PTR_WID'(2);
    cyc();
    rel_wen = 1'b0;
    chk("uf_no_wen", s_wen, 0);
    cyc();
    chk("uf_used", s_used, 0);
    chk("err_sticky", s_err, 1);

    // reset with 5 outstanding, then allocation restarts at 0
    alloc_rdy = 1'b1;
    for (int k = 0; k < 20 && out_list.size() < 5; k++) cyc();
    alloc_rdy = 1'b0;
    chk("out_five", out_list.size(), 5);
    do_rst();
    do_init(1'b0);
    alloc_rdy = 1'b1;
    got = -1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (s_hs != 0 && got < 0) got = s_ptr;
    end
    chk("restart_ptr", got, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fptr_alloc.md
Name: fptr_alloc

Overview:
- Consumer end of the free-pointer FIFO. The init writer fills that FIFO with every pointer 0..2^PTR_WID-1 after reset.
- This block reads free pointers out of the FIFO, prefetches them into a 2-entry skid buffer, and hands one pointer per handshake to the packet writer as a buffer allocation.
- It also owns the FIFO write port after initialisation. Pointers released by the packet reader are muxed back onto that port, and the block tracks how many pointers are outstanding.

Parameters:
- PTR_WID, 9, pointer width. Pool size is 2^PTR_WID.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- init_done  input  1  from the init writer; high when the FIFO fill is complete. Sticky.
- init_wen  input  1  init writer's FIFO write enable.
- init_wdata  input  PTR_WID  init writer's FIFO write data.
- fptr_fifo_wen  output  1  FIFO write enable (muxed).
- fptr_fifo_wdata  output  PTR_WID  FIFO write data (muxed).
- fptr_fifo_empty  input  1  FIFO empty flag.
- fptr_fifo_ren  output  1  FIFO read enable.
- fptr_fifo_rdata  input  PTR_WID  FIFO read data, valid exactly 1 cycle after fptr_fifo_ren.
- alloc_vld  output  1  a free pointer is offered.
- alloc_ptr  output  PTR_WID  the offered pointer.
- alloc_rdy  input  1  consumer accepts the pointer.
- rel_wen  input  1  release a pointer back to the pool.
- rel_ptr  input  PTR_WID  pointer being released.
- used_cnt  output  PTR_WID+1  pointers currently allocated and not yet released.
- err  output  1  sticky protocol error.

Behaviour:
- Reset values: fptr_fifo_ren=0, alloc_vld=0, alloc_ptr=0, used_cnt=0, err=0. Skid buffer and in-flight flag are cleared; state=WAIT.
- State machine, 2 states:
  - WAIT: no FIFO reads. Goes to RUN on the first cycle init_done=1.
  - RUN: stays there until rst.
  - Reset mid-operation returns to WAIT. All buffered pointers are discarded; the init writer refills the FIFO.
- Write mux, combinational:
  - While init_done=0, fptr_fifo_wen/wdata = init_wen/init_wdata.
  - While init_done=1, fptr_fifo_wen/wdata = rel_wen/rel_ptr.
  - rel_wen=1 while init_done=0 is dropped and sets err.
- Prefetch:
  - occ = skid entries (0..2); inflight = 1 if fptr_fifo_ren was asserted last cycle.
  - In RUN, assert fptr_fifo_ren when fptr_fifo_empty=0 and (occ + inflight − pop_this_cycle) < 2, where pop = alloc_vld & alloc_rdy.
  - The returning rdata is written into the skid in the cycle after ren.
- Output timing:
  - alloc_vld = (occ != 0); alloc_ptr = oldest skid entry (registered head, no comb path from rdata).
  - FIFO order is preserved.
  - Latency: first alloc_vld rises 3 cycles after init_done rises (WAIT→RUN, ren, rdata capture).
- Handshake:
  - Transfer occurs when alloc_vld & alloc_rdy.
  - alloc_ptr is held stable while alloc_vld=1 and alloc_rdy=0.
  - Sustained throughput is 1 pointer/cycle when the FIFO is non-empty.
- Pool exhaustion: while the FIFO is empty, no ren is issued. alloc_vld drops once the skid drains and no error is raised.
- Used counter:
  - +1 on transfer, −1 on rel_wen (RUN only). Simultaneous transfer and release leaves it unchanged.
  - Release while used_cnt=0 with no simultaneous transfer sets err and the counter is unchanged (no underflow).
- Simultaneous ren and rel_wen are legal; the FIFO has independent ports.
- err clears only on rst.

Test Plan:
- Reset, then init fill with PTR_WID=4 (16 ptrs); hold alloc_rdy=0 → fptr_fifo_ren pulses exactly twice. alloc_vld rises 3 cycles after init_done with alloc_ptr=0 and stays stable; fptr_fifo_wen mirrors init_wen.
- alloc_rdy=1 continuously → alloc_ptr sequence 0,1,…,15 at one per cycle. alloc_vld then falls, used_cnt=16, no further ren, err=0.
- After exhaustion, release ptr 7 → fptr_fifo_wen=1 with wdata=7, used_cnt=15. Next alloc_ptr=7 after FIFO latency, then used_cnt=16.
- Random alloc_rdy toggling plus releases over 1000 cycles → no duplicate pointer outstanding at any time, and used_cnt equals the scoreboard count.
- rel_wen during init, and a release with used_cnt=0 → err=1 and sticky, used_cnt stays 0, and neither release reaches fptr_fifo_wen.
- Assert rst mid-stream with 5 outstanding → all outputs return to reset values immediately. After re-init, allocation restarts at ptr 0.
